// File: rtl/pipeline_skid_register.sv
// pipeline_skid_register
//
// Pipeline-stage register for EX/MEM-style datapath stages. It carries a valid/ready
// handshake and a two-entry skid buffer, so a stage can run at full throughput under
// back-pressure. A synchronous flush inserts a bubble, and Tick qualifies every state
// change. Q can be released to high impedance so that several stages can share one bus.
//
// Parameters
//   NrOfBits     payload width (>= 1)
//   BubbleValue  value held in both slots after a reset, a flush or a drain
//
// Ports
//   Clock      in   1         system clock; state updates on its rising edge
//   Reset      in   1         asynchronous reset, active low
//   Tick       in   1         clock-enable qualifier; state holds while it is 0
//   flush      in   1         synchronous flush request, active high
//   in_valid   in   1         upstream presents data on D
//   in_ready   out  1         stage can accept D
//   D          in   NrOfBits  payload in
//   out_valid  out  1         Q holds valid data
//   out_ready  in   1         downstream accepts Q
//   cs         in   1         1 = Q released to all-Z, 0 = Q driven
//   Q          out  NrOfBits  payload out (main slot)
//   occupancy  out  2         number of entries held: 0, 1 or 2

module pipeline_skid_register #(
  parameter int unsigned          NrOfBits    = 32,
  parameter logic [NrOfBits-1:0]  BubbleValue = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NrOfBits-1:0] D,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                cs,
  output logic [NrOfBits-1:0] Q,
  output logic [1:0]          occupancy
);

  // The encoding equals the occupancy, so the count output decodes directly.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NrOfBits-1:0] main_q, main_d;
  logic [NrOfBits-1:0] skid_q, skid_d;
  logic                out_valid_q, in_ready_q;
  logic [1:0]          occupancy_q;

  logic accept;
  logic pop;

  // The handshake flags are registered copies of the state decode. No combinational
  // path therefore runs from in_valid or out_ready to either ready or valid.
  assign accept = in_valid & in_ready_q & Tick;
  assign pop    = out_valid_q & out_ready & Tick;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Tick) begin
      if (flush) begin
        // Flush wins over any same-cycle accept or pop.
        state_d = StEmpty;
        main_d  = BubbleValue;
        skid_d  = BubbleValue;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (accept) begin
              state_d = StFull;
              main_d  = D;
            end
          end
          StFull: begin
            if (accept && pop) begin
              main_d = D;
            end else if (accept) begin
              // The downstream stage stalled, so the new word parks behind main.
              state_d = StSkid;
              skid_d  = D;
            end else if (pop) begin
              state_d = StEmpty;
              main_d  = BubbleValue;
            end
          end
          StSkid: begin
            // in_ready is low here, so only a pop can occur.
            if (pop) begin
              state_d = StFull;
              main_d  = skid_q;
              skid_d  = BubbleValue;
            end
          end
          default: begin
            // Recovery from an unused encoding.
            state_d = StEmpty;
            main_d  = BubbleValue;
            skid_d  = BubbleValue;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StEmpty;
      main_q      <= BubbleValue;
      skid_q      <= BubbleValue;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= (state_d != StEmpty);
      in_ready_q  <= (state_d != StSkid);
      occupancy_q <= state_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign occupancy = occupancy_q;

  // cs only releases the bus. It has no effect on the handshake.
  assign Q = cs ? {NrOfBits{1'bz}} : main_q;

endmodule

// File: tb/tb_pipeline_skid_register.sv
module tb_pipeline_skid_register;
  localparam int unsigned W   = 32;
  localparam logic [W-1:0] Bub = 32'hB0B0_0001;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Tick = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cs = 1'b0;
  logic [W-1:0] D = '0;
  logic         in_ready, out_valid;
  logic [1:0]   occupancy;
  wire  [W-1:0] q_bus;

  // Another agent on the shared bus drives a known pattern while the DUT is deselected.
  logic [W-1:0] bus_val = 32'h5A5A_C3C3;
  assign q_bus = cs ? bus_val : {W{1'bz}};

  pipeline_skid_register #(.NrOfBits(W), .BubbleValue(Bub)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .cs(cs),
    .Q(q_bus), .occupancy(occupancy)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list holding at most two words.
  logic [W-1:0] mq[$];

  task automatic model_edge();
    bit acc, pp;
    if (!Tick) return;
    acc = in_valid && (mq.size() < 2);
    pp  = out_ready && (mq.size() > 0);
    if (flush) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(D);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".occ"}, W'(occupancy), W'(mq.size()));
    chk({tag, ".valid"}, W'(out_valid), W'(mq.size() > 0));
    chk({tag, ".ready"}, W'(in_ready), W'(mq.size() < 2));
    if (cs) chk({tag, ".bus"}, q_bus, bus_val);
    else    chk({tag, ".q"}, q_bus, (mq.size() > 0) ? mq[0] : Bub);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input bit t, input bit f, input bit v, input logic [W-1:0] d,
                       input bit r, input bit c);
    Tick = t; flush = f; in_valid = v; D = d; out_ready = r; cs = c;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, '0, 0, 0);
    Reset = 1'b0;
    #3;
    mq.delete();
    Reset = 1'b1;
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    bit           t, f, v, r;
    logic [W-1:0] d;
    logic [1:0]   occ;
    bit           ov, ir;
    logic [W-1:0] q;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Table: each row is one clock edge starting from empty, with the outputs expected after it.
    vecs[0]  = '{t:1, f:0, v:1, r:0, d:32'hA,  occ:1, ov:1, ir:1, q:32'hA};
    vecs[1]  = '{t:1, f:0, v:1, r:0, d:32'hB,  occ:2, ov:1, ir:0, q:32'hA};
    vecs[2]  = '{t:1, f:0, v:1, r:0, d:32'hC,  occ:2, ov:1, ir:0, q:32'hA};
    vecs[3]  = '{t:0, f:1, v:1, r:1, d:32'hD,  occ:2, ov:1, ir:0, q:32'hA};
    vecs[4]  = '{t:1, f:0, v:0, r:1, d:32'h0,  occ:1, ov:1, ir:1, q:32'hB};
    vecs[5]  = '{t:1, f:0, v:0, r:1, d:32'h0,  occ:0, ov:0, ir:1, q:Bub};
    vecs[6]  = '{t:1, f:0, v:1, r:1, d:32'hE,  occ:1, ov:1, ir:1, q:32'hE};
    vecs[7]  = '{t:1, f:0, v:1, r:1, d:32'hF,  occ:1, ov:1, ir:1, q:32'hF};
    vecs[8]  = '{t:1, f:0, v:1, r:0, d:32'h10, occ:2, ov:1, ir:0, q:32'hF};
    vecs[9]  = '{t:1, f:1, v:1, r:1, d:32'hC,  occ:0, ov:0, ir:1, q:Bub};
    vecs[10] = '{t:1, f:0, v:1, r:0, d:32'h7,  occ:1, ov:1, ir:1, q:32'h7};
    vecs[11] = '{t:1, f:1, v:0, r:1, d:32'h0,  occ:0, ov:0, ir:1, q:Bub};

    // Reset values, checked while Reset is still low.
    #12;
    chk("rst.occ", W'(occupancy), 0);
    chk("rst.valid", W'(out_valid), 0);
    chk("rst.ready", W'(in_ready), 1);
    chk("rst.q", q_bus, Bub);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].t, vecs[i].f, vecs[i].v, vecs[i].d, vecs[i].r, 0);
      @(posedge Clock);
      #1;
      chk($sformatf("vec%0d.occ", i), W'(occupancy), W'(vecs[i].occ));
      chk($sformatf("vec%0d.valid", i), W'(out_valid), W'(vecs[i].ov));
      chk($sformatf("vec%0d.ready", i), W'(in_ready), W'(vecs[i].ir));
      chk($sformatf("vec%0d.q", i), q_bus, vecs[i].q);
    end

    // The table leaves the stage empty. Re-align the model with it.
    mq.delete();

    // Asynchronous reset in the middle of a cycle while two entries are held.
    drive(1, 0, 1, 32'h11, 0, 0); cycle();
    drive(1, 0, 1, 32'h22, 0, 0); cycle();
    check_model("preload");
    #2;
    Reset = 1'b0;
    #1;
    chk("async.occ", W'(occupancy), 0);
    chk("async.valid", W'(out_valid), 0);
    chk("async.ready", W'(in_ready), 1);
    chk("async.q", q_bus, Bub);
    do_reset();

    // Streaming: the stage should carry one word per cycle.
    for (int i = 1; i <= 20; i++) begin
      drive(1, 0, 1, W'(i), 1, 0);
      cycle();
      chk($sformatf("stream%0d.q", i), q_bus, W'(i));
      chk($sformatf("stream%0d.occ", i), W'(occupancy), 1);
      chk($sformatf("stream%0d.ready", i), W'(in_ready), 1);
    end
    drive(1, 0, 0, '0, 1, 0); cycle();
    check_model("drain");

    // Back-pressure: park 0xB behind 0xA, then release.
    drive(1, 0, 1, 32'hA, 0, 0); cycle();
    drive(1, 0, 1, 32'hB, 0, 0); cycle();
    chk("bp.occ", W'(occupancy), 2);
    chk("bp.ready", W'(in_ready), 0);
    chk("bp.q", q_bus, 32'hA);
    drive(1, 0, 0, '0, 1, 0); cycle();
    chk("bp.q2", q_bus, 32'hB);
    cycle();
    chk("bp.empty", W'(out_valid), 0);
    check_model("bp");

    // Tick gating: every request is ignored for three cycles while Tick is low.
    drive(1, 0, 1, 32'hA, 0, 0); cycle();
    drive(1, 0, 1, 32'hB, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 32'h99, 1, 0);
      cycle();
      chk($sformatf("gate%0d.occ", i), W'(occupancy), 2);
      chk($sformatf("gate%0d.q", i), q_bus, 32'hA);
    end
    drive(1, 0, 0, '0, 1, 0); cycle();
    chk("gate.resume", q_bus, 32'hB);
    check_model("gate");

    // Flush with two entries held and a same-cycle write of 0xC, which must not be stored.
    drive(1, 0, 1, 32'h1, 0, 0); cycle();
    drive(1, 1, 1, 32'hC, 0, 0); cycle();
    chk("flush.occ", W'(occupancy), 0);
    chk("flush.q", q_bus, Bub);
    drive(1, 0, 0, '0, 1, 0); cycle();
    chk("flush.noc", W'(out_valid), 0);

    // Tri-state: deselected, the DUT lets the other agent own the bus while handshakes continue.
    drive(1, 0, 1, 32'h77, 0, 1); cycle();
    check_model("cs.load");
    drive(1, 0, 1, 32'h88, 1, 1); cycle();
    check_model("cs.pop");
    drive(1, 0, 0, '0, 0, 0); #1;
    chk("cs.release", q_bus, 32'h88);

    // Randomised traffic, checked against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3) != 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
            $urandom, $urandom_range(2) != 0, $urandom_range(3) == 0);
      cycle();
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
